enreg_bank: RTL and testbench

Parametrised multi-channel, edge-triggered enable register bank. It is the next generation of the team's single-bit gated D storage element. It holds CHANNELS words of WIDTH bits, written through a valid/ready port in one of four modes (hold, addressed load, broadcast, shift chain). An optional shadow stage publishes all channels atomically on a commit strobe. It sits between control/config logic and datapath consumers that need glitch-free, simultaneously updated parameters.

---
 rtl/enreg_pkg.sv | 17 +
 rtl/enreg_chan.sv | 36 +++
 rtl/enreg_bank.sv | 152 +++++++++++++++
 tb/tb_enreg_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enreg_pkg.sv
// enreg_pkg: shared types and constants for the enable register bank.
//   mode_e    - write mode encoding carried on the 2-bit mode port
//   COUNT_W   - width of the accepted-write counter
//   COUNT_MAX - saturation value of the accepted-write counter
package enreg_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        LOAD  = 2'd1,
        BCAST = 2'd2,
        SHIFT = 2'd3
    } mode_e;

    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/enreg_chan.sv
// enreg_chan: one WIDTH-bit channel register of the enable register bank.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous, active-low; clears the word
//   load     - capture a new value at the next edge
//   sel      - source select: 0 = din (direct write), 1 = shift_in (chain)
//   din      - direct write data
//   shift_in - word from the previous channel in the shift chain
//   dout     - stored word
module enreg_chan
    import enreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             sel,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] shift_in,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= sel ? shift_in : din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/enreg_bank.sv
// enreg_bank: multi-channel edge-triggered enable register bank.
// Holds CHANNELS words of WIDTH bits written through a valid/ready port in
// HOLD / LOAD / BCAST / SHIFT mode. Build option ENREG_SHADOW_EN adds a shadow
// stage so that q only changes, for all channels at once, on a commit strobe;
// without it the stage registers drive q directly and commit is ignored.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous, active-low
//   enable   - global write enable; 0 freezes all state except reset
//   mode     - 0=HOLD, 1=LOAD, 2=BCAST, 3=SHIFT
//   wr_valid - write request
//   wr_ready - bank accepts a write this cycle (combinational)
//   wr_chan  - target channel for LOAD
//   wr_data  - write data
//   commit   - publish stage to q (ENREG_SHADOW_EN only)
//   q        - visible words; channel i at bits [i*WIDTH +: WIDTH]
//   wr_count - saturating count of accepted in-range writes
//   err      - sticky flag: out-of-range LOAD attempted
module enreg_bank
    import enreg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CHW     = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [CHW-1:0]            wr_chan,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [COUNT_W-1:0]        wr_count,
    output logic                      err
);

    mode_e                     mode_op;
    logic                      ready_q;
    logic                      accept;
    logic                      chan_ok;
    logic                      good_wr;
    logic                      bad_load;
    logic                      load_all;
    logic                      shift_op;
    logic [COUNT_W-1:0]        count_q;
    logic                      err_q;
    logic [WIDTH-1:0]          stage [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] stage_flat;

    assign mode_op = mode_e'(mode);

    // Ready comes up on the first edge out of reset, so no write can land on
    // the same edge that releases reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign wr_ready = ready_q & enable & (mode_op != HOLD);
    assign accept   = wr_valid & wr_ready;

    // Only reachable when CHANNELS is not a power of two.
    assign chan_ok  = (32'(wr_chan) < CHANNELS);
    assign bad_load = accept & (mode_op == LOAD) & ~chan_ok;
    assign good_wr  = accept & ~bad_load;

    always_comb begin
        load_all = 1'b0;
        shift_op = 1'b0;
        case (mode_op)
            BCAST:   load_all = 1'b1;
            SHIFT: begin
                load_all = 1'b1;
                shift_op = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic             chan_load;
        logic [WIDTH-1:0] chain_in;

        assign chan_load = accept &
                           (load_all | ((mode_op == LOAD) && (wr_chan == CHW'(i))));

        if (i == 0) begin : g_head
            assign chain_in = wr_data;
        end else begin : g_tail
            assign chain_in = stage[i-1];
        end

        enreg_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .load     (chan_load),
            .sel      (shift_op),
            .din      (wr_data),
            .shift_in (chain_in),
            .dout     (stage[i])
        );

        assign stage_flat[i*WIDTH +: WIDTH] = stage[i];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (good_wr && (count_q != COUNT_MAX)) begin
                count_q <= count_q + COUNT_W'(1);
            end
            if (bad_load) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wr_count = count_q;
    assign err      = err_q;

`ifdef ENREG_SHADOW_EN
    logic [CHANNELS*WIDTH-1:0] shadow_q;

    // Copies the pre-edge stage, so a write on the commit edge waits for the
    // next commit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow_q <= '0;
        end else if (enable && commit) begin
            shadow_q <= stage_flat;
        end
    end

    assign q = shadow_q;
`else
    logic unused_commit;

    assign unused_commit = commit;
    assign q             = stage_flat;
`endif

endmodule

// File: tb/tb_enreg_bank.sv
// tb_enreg_bank: directed bench for enreg_bank. Stimulus pushes hand-computed
// expectations into a queue tagged with the cycle they apply to; a separate
// monitor pops and compares them at the falling edge of that cycle.
// Two instances: a 4-channel bank for the main sequence and a 3-channel bank
// for the out-of-range LOAD case. Works with or without ENREG_SHADOW_EN.
module tb_enreg_bank;
  import enreg_pkg::*;

`ifdef ENREG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 4-channel instance
  logic        reset, enable, wr_valid, commit, wr_ready, err;
  logic [1:0]  mode, wr_chan;
  logic [7:0]  wr_data;
  logic [31:0] q;
  logic [15:0] wr_count;

  // 3-channel instance
  logic        reset3, enable3, wr_valid3, commit3, wr_ready3, err3;
  logic [1:0]  mode3, wr_chan3;
  logic [7:0]  wr_data3;
  logic [23:0] q3;
  logic [15:0] wr_count3;

  enreg_bank #(
    .WIDTH    (8),
    .CHANNELS (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .commit   (commit),
    .q        (q),
    .wr_count (wr_count),
    .err      (err)
  );

  enreg_bank #(
    .WIDTH    (8),
    .CHANNELS (3)
  ) dut3 (
    .clock    (clock),
    .reset    (reset3),
    .enable   (enable3),
    .mode     (mode3),
    .wr_valid (wr_valid3),
    .wr_ready (wr_ready3),
    .wr_chan  (wr_chan3),
    .wr_data  (wr_data3),
    .commit   (commit3),
    .q        (q3),
    .wr_count (wr_count3),
    .err      (err3)
  );

  typedef struct packed {
    int          due;
    logic        on3;
    logic [31:0] q;
    logic [15:0] cnt;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] qx(input logic [31:0] sh, input logic [31:0] dir);
    return SHADOW ? sh : dir;
  endfunction

  task automatic expect_out(input string n, input logic on3, input logic [31:0] eq,
                            input logic [15:0] ec, input logic ee, input logic er);
    exp_t e;
    e.due = cyc;
    e.on3 = on3;
    e.q   = eq;
    e.cnt = ec;
    e.err = ee;
    e.rdy = er;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // One clock edge with the given inputs on the 4-channel instance.
  task automatic op(input logic rst, input logic en, input logic [1:0] m, input logic v,
                    input logic [1:0] ch, input logic [7:0] d, input logic c);
    @(negedge clock);
    #1;
    reset = rst; enable = en; mode = m; wr_valid = v;
    wr_chan = ch; wr_data = d; commit = c;
    @(posedge clock);
    #1;
  endtask

  task automatic op3(input logic rst, input logic en, input logic [1:0] m, input logic v,
                     input logic [1:0] ch, input logic [7:0] d, input logic c);
    @(negedge clock);
    #1;
    reset3 = rst; enable3 = en; mode3 = m; wr_valid3 = v;
    wr_chan3 = ch; wr_data3 = d; commit3 = c;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares every expectation due in the current cycle.
  initial begin
    exp_t        e;
    string       n;
    logic [31:0] aq;
    logic [15:0] ac;
    logic        ae, ar;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.on3) begin
          aq = {8'h00, q3}; ac = wr_count3; ae = err3; ar = wr_ready3;
        end else begin
          aq = q; ac = wr_count; ae = err; ar = wr_ready;
        end
        checks = checks + 1;
        if (e.due != cyc || aq !== e.q || ac !== e.cnt || ae !== e.err ||
            ar !== e.rdy) begin
          errors = errors + 1;
          $display("FAIL %s: got q=%h cnt=%h err=%b rdy=%b @%0d, want q=%h cnt=%h err=%b rdy=%b @%0d",
                   n, aq, ac, ae, ar, cyc, e.q, e.cnt, e.err, e.rdy, e.due);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b1; mode = BCAST; wr_valid = 1'b1;
    wr_chan = 2'd1; wr_data = 8'h77; commit = 1'b1;
    reset3 = 1'b0; enable3 = 1'b1; mode3 = HOLD; wr_valid3 = 1'b0;
    wr_chan3 = 2'd0; wr_data3 = 8'h00; commit3 = 1'b0;

    // Reset held with write and commit requested.
    repeat (3) op(0, 1, BCAST, 1, 1, 8'h77, 1);
    expect_out("reset_hold", 0, 32'h0, 16'h0, 0, 0);
    checks = checks + 1;
    if (q !== 32'h0 || wr_count !== 16'h0 || err !== 1'b0 || wr_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_hold_direct: got q=%h cnt=%h err=%b rdy=%b, want all 0",
               q, wr_count, err, wr_ready);
    end

    // Release edge itself must not accept the pending write.
    op(1, 1, LOAD, 1, 1, 8'hEE, 0);
    expect_out("ready_release", 0, 32'h0, 16'h0, 0, 1);

    // Addressed loads then commit.
    op(1, 1, LOAD, 1, 2, 8'hA5, 0);
    expect_out("load_ch2", 0, qx(32'h0, 32'h00A50000), 16'd1, 0, 1);
    op(1, 1, LOAD, 1, 0, 8'h3C, 0);
    expect_out("load_ch0", 0, qx(32'h0, 32'h00A5003C), 16'd2, 0, 1);
    op(1, 1, HOLD, 0, 0, 8'h00, 1);
    expect_out("load_commit", 0, 32'h00A5003C, 16'd2, 0, 0);
    checks = checks + 1;
    if (q !== 32'h00A5003C) begin
      errors = errors + 1;
      $display("FAIL load_commit_direct: got q=%h, want 00a5003c", q);
    end

    // Fresh start, then the shift chain.
    op(0, 1, HOLD, 0, 0, 8'h00, 0);
    expect_out("reset_clear", 0, 32'h0, 16'h0, 0, 0);
    op(1, 1, HOLD, 0, 0, 8'h00, 0);
    op(1, 1, SHIFT, 1, 0, 8'h11, 0);
    op(1, 1, SHIFT, 1, 0, 8'h22, 0);
    op(1, 1, SHIFT, 1, 0, 8'h33, 0);
    expect_out("shift3", 0, qx(32'h0, 32'h00112233), 16'd3, 0, 1);
    op(1, 1, SHIFT, 1, 0, 8'h44, 0);
    op(1, 1, SHIFT, 1, 0, 8'h55, 0);
    expect_out("shift5", 0, qx(32'h0, 32'h22334455), 16'd5, 0, 1);
    op(1, 1, HOLD, 0, 0, 8'h00, 1);
    expect_out("shift_commit", 0, 32'h22334455, 16'd5, 0, 0);

    // Write and commit on the same edge.
    op(1, 1, BCAST, 1, 0, 8'hFF, 0);
    op(1, 1, HOLD, 0, 0, 8'h00, 1);
    expect_out("bcast_commit", 0, 32'hFFFFFFFF, 16'd6, 0, 0);
    op(1, 1, BCAST, 1, 0, 8'h01, 1);
    expect_out("collision", 0, qx(32'hFFFFFFFF, 32'h01010101), 16'd7, 0, 1);
    op(1, 1, HOLD, 0, 0, 8'h00, 1);
    expect_out("collision_next", 0, 32'h01010101, 16'd7, 0, 0);

    // enable=0 freezes everything, including commit.
    op(1, 0, LOAD, 1, 0, 8'h5A, 1);
    expect_out("gated", 0, 32'h01010101, 16'd7, 0, 0);
    op(1, 1, HOLD, 0, 0, 8'h00, 1);
    expect_out("gated_commit", 0, 32'h01010101, 16'd7, 0, 0);

    // Saturation: 65540 broadcasts starting from a count of 7.
    for (int i = 0; i < 65527; i++) op(1, 1, BCAST, 1, 0, 8'h5A, 0);
    expect_out("sat_fffe", 0, qx(32'h01010101, 32'h5A5A5A5A), 16'hFFFE, 0, 1);
    op(1, 1, BCAST, 1, 0, 8'h5A, 0);
    expect_out("sat_ffff", 0, qx(32'h01010101, 32'h5A5A5A5A), 16'hFFFF, 0, 1);
    checks = checks + 1;
    if (wr_count !== 16'hFFFF) begin
      errors = errors + 1;
      $display("FAIL sat_ffff_direct: got cnt=%h, want ffff", wr_count);
    end
    for (int i = 0; i < 11; i++) op(1, 1, BCAST, 1, 0, 8'h5A, 0);
    op(1, 1, BCAST, 1, 0, 8'h96, 0);
    expect_out("sat_hold", 0, qx(32'h01010101, 32'h96969696), 16'hFFFF, 0, 1);

    // Reset in the middle of a write+commit stream.
    op(0, 1, BCAST, 1, 0, 8'h33, 1);
    expect_out("reset_mid", 0, 32'h0, 16'h0, 0, 0);
    checks = checks + 1;
    if (q !== 32'h0 || wr_count !== 16'h0) begin
      errors = errors + 1;
      $display("FAIL reset_mid_direct: got q=%h cnt=%h, want 0", q, wr_count);
    end

    // 3-channel instance: out-of-range LOAD.
    op3(1, 1, HOLD, 0, 0, 8'h00, 0);
    expect_out("d3_release", 1, 32'h0, 16'h0, 0, 0);
    op3(1, 1, LOAD, 1, 1, 8'h42, 0);
    expect_out("d3_load", 1, qx(32'h0, 32'h00004200), 16'd1, 0, 1);
    op3(1, 1, LOAD, 1, 3, 8'h99, 0);
    expect_out("d3_oor", 1, qx(32'h0, 32'h00004200), 16'd1, 1, 1);
    checks = checks + 1;
    if (err3 !== 1'b1 || wr_count3 !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL d3_oor_direct: got err=%b cnt=%h, want err=1 cnt=1", err3, wr_count3);
    end
    op3(1, 1, HOLD, 0, 0, 8'h00, 1);
    expect_out("d3_oor_commit", 1, 32'h00004200, 16'd1, 1, 0);
    op3(1, 1, LOAD, 1, 2, 8'h77, 0);
    expect_out("d3_sticky", 1, qx(32'h00004200, 32'h00774200), 16'd2, 1, 1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #2;
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: got no comparison, want one", name_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
